// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: data/amount widths, op encodings
// and the bit-reverse helper used to build right shifts on a left shifter.
package shift_arbiter_pkg;

  localparam int SH_DATA_W  = 32;
  localparam int SH_SHAMT_W = 5;

  localparam logic [1:0] SH_OP_SLL = 2'b00;
  localparam logic [1:0] SH_OP_SRL = 2'b01;
  localparam logic [1:0] SH_OP_SRA = 2'b10;
  localparam logic [1:0] SH_OP_RSV = 2'b11;

  // Reverse bit order; bit 0 becomes bit 31.
  function automatic logic [SH_DATA_W-1:0] bitrev32(input logic [SH_DATA_W-1:0] d);
    logic [SH_DATA_W-1:0] r;
    for (int i = 0; i < SH_DATA_W; i++) begin
      r[i] = d[SH_DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shamt_dec_5to32.sv
// Shift-amount decoder: 5-bit amount to the one-hot control vector expected
// by the external left shifter (bit k set = shift left by k).
module shamt_dec_5to32
  import shift_arbiter_pkg::*;
(
  input  logic [SH_SHAMT_W-1:0] shamt,
  output logic [SH_DATA_W-1:0]  onehot
);

  // Exactly one bit set for every amount, including zero (bit 0).
  always_comb begin
    onehot        = '0;
    onehot[shamt] = 1'b1;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared one-hot-controlled left
// shifter. Right shifts are formed by reversing the operand in and the
// result out; arithmetic right shift ORs in a sign-fill mask. Results are
// registered behind a valid/ready handshake together with the requester id.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int ID_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [SH_DATA_W-1:0]  req0_data,
  input  logic [SH_SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]            req0_op,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [SH_DATA_W-1:0]  req1_data,
  input  logic [SH_SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]            req1_op,

  output logic [SH_DATA_W-1:0]  sh_datain,
  output logic [SH_DATA_W-1:0]  sh_shift,
  input  logic [SH_DATA_W-1:0]  sh_dataout,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [SH_DATA_W-1:0]  resp_data,
  output logic [ID_W-1:0]       resp_id
);

  logic                  last_grant;
  logic                  slot_free;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic [SH_DATA_W-1:0]  sel_data;
  logic [SH_SHAMT_W-1:0] sel_shamt;
  logic [1:0]            sel_op;
  logic                  reversed;
  logic [SH_DATA_W-1:0]  fill;
  logic [SH_DATA_W-1:0]  result;

  // The output slot can take a new result when empty or being drained.
  assign slot_free = ~resp_valid | resp_ready;

  // Round-robin grant: a lone requester always wins, on contention the one
  // that did not win last time goes. Nothing is granted during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot_free && !rst) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // A grant is only ever given to a valid requester, so grant means accept.
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Steer the granted request onto the shifter; idle inputs keep it benign.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    sel_op    = SH_OP_SLL;
    if (grant0) begin
      sel_data  = req0_data;
      sel_shamt = req0_shamt;
      sel_op    = req0_op;
    end else if (grant1) begin
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
      sel_op    = req1_op;
    end
  end

  shamt_dec_5to32 u_shamt_dec (
    .shamt  (sel_shamt),
    .onehot (sh_shift)
  );

  // Right shifts run through the left shifter on a bit-reversed operand;
  // the reserved op falls through as a plain left shift.
  always_comb begin
    reversed  = (sel_op == SH_OP_SRL) || (sel_op == SH_OP_SRA);
    sh_datain = reversed ? bitrev32(sel_data) : sel_data;
    fill      = ~({SH_DATA_W{1'b1}} >> sel_shamt);
    if (reversed) begin
      result = bitrev32(sh_dataout);
      if ((sel_op == SH_OP_SRA) && sel_data[SH_DATA_W-1]) begin
        result = result | fill;
      end
    end else begin
      result = sh_dataout;
    end
  end

  // Result register and round-robin history; a new accept overwrites a
  // result being drained in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= result;
      resp_id    <= ID_W'(grant1);
      last_grant <= grant1;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: behavioural shifter on the sh_* ports, directed
// scenarios with hand-derived results, then a randomized run against a
// transaction-level reference model.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_data, r1_data;
  logic [4:0]  r0_shamt, r1_shamt;
  logic [1:0]  r0_op, r1_op;
  logic [31:0] sh_datain, sh_shift, sh_dataout;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [0:0]  resp_id;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.ID_W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (r0_valid),
    .req0_ready (r0_ready),
    .req0_data  (r0_data),
    .req0_shamt (r0_shamt),
    .req0_op    (r0_op),
    .req1_valid (r1_valid),
    .req1_ready (r1_ready),
    .req1_data  (r1_data),
    .req1_shamt (r1_shamt),
    .req1_op    (r1_op),
    .sh_datain  (sh_datain),
    .sh_shift   (sh_shift),
    .sh_dataout (sh_dataout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External one-hot left shifter.
  always_comb begin
    sh_dataout = '0;
    for (int k = 0; k < 32; k++) begin
      if (sh_shift[k]) sh_dataout = sh_datain << k;
    end
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b01:   return d >> s;
      2'b10:   return sd >>> s;
      default: return d << s;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_valid   = 1'b0;
    r1_valid   = 1'b0;
    resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r0_valid = 1'b1; r0_data = 32'h1; r0_shamt = 5'd1; r0_op = 2'b00;
    r1_valid = 1'b1; r1_data = 32'h2; r1_shamt = 5'd1; r1_op = 2'b00;
    resp_ready = 1'b1;
    tick(); tick();
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b exp 00", r0_ready, r1_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_id !== 1'b0) begin
      errors++; $display("FAIL reset_resp got v=%b d=%h id=%b exp v=0 d=0 id=0",
                         resp_valid, resp_data, resp_id);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (sh_shift !== 32'h1 || sh_datain !== 32'h0) begin
      errors++; $display("FAIL idle_shifter got shift=%h din=%h exp 1/0", sh_shift, sh_datain);
    end
  endtask

  task automatic test_sll();
    r0_valid = 1'b1; r0_data = 32'h0000_0001; r0_shamt = 5'd4; r0_op = 2'b00;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL sll_ready got %b%b exp 10", r0_ready, r1_ready);
    end
    checks++;
    if (sh_shift !== 32'h0000_0010) begin
      errors++; $display("FAIL sll_shift got %h exp 00000010", sh_shift);
    end
    tick();
    r0_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0010 || resp_id !== 1'b0) begin
      errors++; $display("FAIL sll_resp got v=%b d=%h id=%b exp v=1 d=00000010 id=0",
                         resp_valid, resp_data, resp_id);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL sll_drain got v=%b exp 0", resp_valid);
    end
  endtask

  task automatic test_srl_sra();
    logic [31:0] din [3]   = '{32'h8000_0000, 32'h8000_0000, 32'hF000_000F};
    logic [4:0]  sa  [3]   = '{5'd31, 5'd31, 5'd0};
    logic [1:0]  opv [3]   = '{2'b01, 2'b10, 2'b10};
    logic [31:0] expd [3]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hF000_000F};
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r1_valid = 1'b1; r1_data = din[i]; r1_shamt = sa[i]; r1_op = opv[i];
      #1;
      checks++;
      if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
        errors++; $display("FAIL right_ready[%0d] got %b%b exp 01", i, r0_ready, r1_ready);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== expd[i] || resp_id !== 1'b1) begin
        errors++; $display("FAIL right_resp[%0d] got v=%b d=%h id=%b exp v=1 d=%h id=1",
                           i, resp_valid, resp_data, resp_id, expd[i]);
      end
    end
    idle();
  endtask

  task automatic test_round_robin();
    logic [31:0] expd;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0_valid = 1'b1; r0_data = 32'h10 + i; r0_shamt = 5'd1; r0_op = 2'b00;
      r1_valid = 1'b1; r1_data = 32'hF000_0000 + i; r1_shamt = 5'd4; r1_op = 2'b01;
      #1;
      checks++;
      if (r0_ready !== (i % 2 == 0) || r1_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL rr_ready[%0d] got %b%b exp %b%b", i, r0_ready, r1_ready,
                           (i % 2 == 0), (i % 2 == 1));
      end
      expd = (i % 2 == 0) ? ref_shift(r0_data, 5'd1, 2'b00) : ref_shift(r1_data, 5'd4, 2'b01);
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 1'((i % 2)) || resp_data !== expd) begin
        errors++; $display("FAIL rr_resp[%0d] got v=%b id=%b d=%h exp v=1 id=%0d d=%h",
                           i, resp_valid, resp_id, resp_data, i % 2, expd);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    r0_valid = 1'b1; r0_data = 32'h0000_005A; r0_shamt = 5'd0; r0_op = 2'b00;
    resp_ready = 1'b0;
    tick();
    r0_data = 32'h0000_0003; r0_shamt = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (r0_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, r0_ready);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h0000_005A || resp_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=0000005a", i,
                           resp_valid, resp_data);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b exp 1", r0_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0000_000C) begin
      errors++; $display("FAIL bp_replace got v=%b d=%h exp v=1 d=0000000c", resp_valid, resp_data);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    r0_valid = 1'b1; r0_data = 32'h0000_0007; r0_shamt = 5'd3; r0_op = 2'b00;
    resp_ready = 1'b0;
    tick();
    r1_valid = 1'b1; r1_data = 32'h0000_0009; r1_shamt = 5'd1; r1_op = 2'b00;
    resp_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ready got %b%b exp 00", r0_ready, r1_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_discard got v=%b exp 0", resp_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_first got %b%b exp 10", r0_ready, r1_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'h0000_0038) begin
      errors++; $display("FAIL mid_rst_resp got v=%b id=%b d=%h exp v=1 id=0 d=00000038",
                         resp_valid, resp_id, resp_data);
    end
    idle();
    idle();
  endtask

  task automatic test_boundaries();
    resp_ready = 1'b1;
    r0_valid = 1'b1; r0_data = 32'h0000_0001; r0_shamt = 5'd31; r0_op = 2'b11;
    #1;
    checks++;
    if (sh_shift !== 32'h8000_0000) begin
      errors++; $display("FAIL rsv_shift got %h exp 80000000", sh_shift);
    end
    tick();
    checks++;
    if (resp_data !== 32'h8000_0000) begin
      errors++; $display("FAIL rsv_result got %h exp 80000000", resp_data);
    end
    r0_data = 32'hDEAD_BEEF; r0_shamt = 5'd0; r0_op = 2'b00;
    #1;
    checks++;
    if (sh_shift !== 32'h0000_0001) begin
      errors++; $display("FAIL sll0_shift got %h exp 00000001", sh_shift);
    end
    tick();
    checks++;
    if (resp_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sll0_result got %h exp deadbeef", resp_data);
    end
    idle();
  endtask

  task automatic test_random();
    logic        m_valid, m_lg, m_id;
    logic [31:0] m_data;
    logic        slot, e0, e1, acc0, acc1;
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_valid = 1'b0; m_lg = 1'b1; m_id = 1'b0; m_data = '0;
    acc0 = 1'b1; acc1 = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!r0_valid || acc0) begin
        r0_valid = ($urandom_range(0, 3) != 0);
        r0_data  = $urandom; r0_shamt = 5'($urandom_range(0, 31)); r0_op = 2'($urandom_range(0, 3));
      end
      if (!r1_valid || acc1) begin
        r1_valid = ($urandom_range(0, 3) != 0);
        r1_data  = $urandom; r1_shamt = 5'($urandom_range(0, 31)); r1_op = 2'($urandom_range(0, 3));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      slot = !m_valid || resp_ready;
      e0 = slot && r0_valid && (!r1_valid || m_lg);
      e1 = slot && r1_valid && (!r0_valid || !m_lg);
      checks++;
      if (r0_ready !== e0 || r1_ready !== e1) begin
        errors++; $display("FAIL rand_ready[%0d] got %b%b exp %b%b", n, r0_ready, r1_ready, e0, e1);
      end
      if (e0) begin
        m_valid = 1'b1; m_id = 1'b0; m_lg = 1'b0;
        m_data = ref_shift(r0_data, r0_shamt, r0_op);
      end else if (e1) begin
        m_valid = 1'b1; m_id = 1'b1; m_lg = 1'b1;
        m_data = ref_shift(r1_data, r1_shamt, r1_op);
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      acc0 = e0; acc1 = e1;
      tick();
      checks++;
      if (resp_valid !== m_valid || (m_valid && (resp_data !== m_data || resp_id !== m_id))) begin
        errors++; $display("FAIL rand_resp[%0d] got v=%b d=%h id=%b exp v=%b d=%h id=%b",
                           n, resp_valid, resp_data, resp_id, m_valid, m_data, m_id);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r0_data = '0; r0_shamt = '0; r0_op = '0;
    r1_valid = 1'b0; r1_data = '0; r1_shamt = '0; r1_op = '0;
    resp_ready = 1'b0;
    test_reset();
    test_sll();
    test_srl_sra();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_boundaries();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
